// File: rtl/load_store_unit_if.sv
// CPU request/response channel and single-port RAM port of the load/store unit.
// The unit connects through the slave modport; the CPU/RAM side uses master.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [11:0] ram_address;
    logic [31:0] ram_data_in;
    logic        ram_store;
    logic        ram_load;
    logic [31:0] ram_data_out;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  ram_address, ram_data_in, ram_store, ram_load
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_data_out,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output ram_address, ram_data_in, ram_store, ram_load
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a one-cycle-latency word RAM.
// Sub-word stores are done as read-modify-write: LOAD, WAIT, WRITE.
module load_store_unit (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic [15:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [11:0] ram_address_q, ram_address_d;
    logic [31:0] ram_data_in_q, ram_data_in_d;
    logic        req_err;

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  offset);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{offset, 3'b000} +: 8];
        h = word[{offset[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b100:  extend_load = {24'h0, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b101:  extend_load = {16'h0, h};
            default: extend_load = word;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [15:0] wdata,
                                                input logic        half,
                                                input logic [1:0]  offset);
        logic [31:0] m;
        m = word;
        if (half) m[{offset[1], 4'b0000} +: 16] = wdata;
        else      m[{offset, 3'b000} +: 8]      = wdata[7:0];
        return m;
    endfunction

    always_comb begin
        req_err = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b100: req_err = 1'b0;
            3'b001, 3'b101: req_err = bus.req_addr[0];
            3'b010:         req_err = |bus.req_addr[1:0];
            default:        req_err = 1'b1;
        endcase
        if (bus.req_we && bus.req_funct3[2]) req_err = 1'b1;
        if (|bus.req_addr[31:14])            req_err = 1'b1;
    end

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        we_d          = we_q;
        funct3_d      = funct3_q;
        offset_d      = offset_q;
        wdata_d       = wdata_q;
        err_d         = err_q;
        rdata_d       = rdata_q;
        ram_address_d = ram_address_q;
        ram_data_in_d = ram_data_in_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d          = bus.req_we;
                    funct3_d      = bus.req_funct3;
                    offset_d      = bus.req_addr[1:0];
                    wdata_d       = bus.req_wdata[15:0];
                    ram_address_d = bus.req_addr[13:2];
                    err_d         = req_err;
                    rdata_d       = '0;
                    if (req_err) begin
                        state_d = DONE;
                    end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
                        ram_data_in_d = bus.req_wdata;
                        state_d       = WRITE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD:  state_d = WAIT;
            WAIT: begin
                // Sub-word stores merge into the word just read; loads keep the extended result.
                if (we_q) begin
                    ram_data_in_d = merge_store(bus.ram_data_out, wdata_q, funct3_q[0], offset_q);
                    state_d       = WRITE;
                end else begin
                    rdata_d = extend_load(bus.ram_data_out, funct3_q, offset_q);
                    state_d = DONE;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            funct3_q      <= 3'b000;
            offset_q      <= 2'b00;
            wdata_q       <= '0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            ram_address_q <= '0;
            ram_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            funct3_q      <= funct3_d;
            offset_q      <= offset_d;
            wdata_q       <= wdata_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            ram_address_q <= ram_address_d;
            ram_data_in_q <= ram_data_in_d;
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.resp_valid  = (state_q == DONE);
    assign bus.resp_err    = (state_q == DONE) && err_q;
    assign bus.resp_rdata  = (state_q == DONE) ? rdata_q : 32'h0;
    assign bus.ram_load    = (state_q == LOAD);
    assign bus.ram_store   = (state_q == WRITE);
    assign bus.ram_address = ram_address_q;
    assign bus.ram_data_in = ram_data_in_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-during-RMW sequence,
// and random traffic checked against a byte-addressed reference memory.
module tb_load_store_unit;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    load_store_unit_if bus ();
    load_store_unit dut (.clk(clk), .reset(reset), .bus(bus.slave));

    // Word RAM behind the unit: read data appears the cycle after ram_load.
    logic [31:0] ram [0:4095];
    always @(posedge clk) begin
        if (bus.ram_store) ram[bus.ram_address] = bus.ram_data_in;
        if (bus.ram_load)  bus.ram_data_out <= ram[bus.ram_address];
    end

    logic [7:0] ref_mem [0:16383];

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  lat;
        logic [3:0]  loads;
        logic [3:0]  stores;
        logic [11:0] strobe_addr;
        logic        addr_bad;
        logic        data_bad;
        logic        excl_bad;
        logic        quiet_bad;
        logic        pulse_bad;
    } obs_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic [11:0] idx;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: byte memory, widths 1/2/4, rules applied directly.
    task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic exp_err,
                            output logic [31:0] exp_rdata, output int exp_lat,
                            output logic [31:0] exp_word);
        int          size;
        logic [31:0] v;
        size      = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        exp_err   = (f3 == 3'd3) || (f3 > 3'd5) || (we && f3[2]) ||
                    (addr % size != 0) || (addr >= 32'h4000);
        exp_rdata = 32'h0;
        exp_lat   = 1;
        exp_word  = 32'h0;
        if (!exp_err) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];
                exp_lat = (size == 4) ? 2 : 4;
            end else begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v = v | (32'(ref_mem[addr + i]) << (8*i));
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                exp_rdata = v;
                exp_lat   = 3;
            end
            for (int i = 0; i < 4; i++) exp_word[8*i +: 8] = ref_mem[(addr & ~32'h3) + i];
        end
    endtask

    // Called at a falling edge; returns at a falling edge one cycle after the response.
    task automatic exec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_word, output obs_t o);
        int waited;
        o      = '0;
        waited = 0;
        while (!bus.req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.ram_load) begin
                o.loads       = o.loads + 4'd1;
                o.strobe_addr = bus.ram_address;
                if (bus.ram_address != addr[13:2]) o.addr_bad = 1'b1;
            end
            if (bus.ram_store) begin
                o.stores      = o.stores + 4'd1;
                o.strobe_addr = bus.ram_address;
                if (bus.ram_address != addr[13:2]) o.addr_bad = 1'b1;
                if (bus.ram_data_in != exp_word)   o.data_bad = 1'b1;
            end
            if (bus.ram_load && bus.ram_store) o.excl_bad = 1'b1;
            if (bus.resp_valid) begin
                o.lat   = 4'(k);
                o.err   = bus.resp_err;
                o.rdata = bus.resp_rdata;
                break;
            end else if (bus.resp_err || bus.resp_rdata != 32'h0) begin
                o.quiet_bad = 1'b1;
            end
        end
        @(negedge clk);
        o.pulse_bad = bus.resp_valid;
    endtask

    task automatic check_op(input string tag, input obs_t o, input logic exp_err,
                            input logic [31:0] exp_rdata, input int exp_lat);
        check({tag, " latency"},   32'(o.lat),    32'(exp_lat));
        check({tag, " resp_err"},  32'(o.err),    32'(exp_err));
        check({tag, " rdata"},     o.rdata,       exp_rdata);
        check({tag, " loads"},     32'(o.loads),  (exp_lat >= 3) ? 32'd1 : 32'd0);
        check({tag, " stores"},    32'(o.stores), (exp_lat == 2 || exp_lat == 4) ? 32'd1 : 32'd0);
        check({tag, " addr"},      32'(o.addr_bad),  32'd0);
        check({tag, " wdata"},     32'(o.data_bad),  32'd0);
        check({tag, " exclusive"}, 32'(o.excl_bad),  32'd0);
        check({tag, " idle zero"}, 32'(o.quiet_bad), 32'd0);
        check({tag, " one pulse"}, 32'(o.pulse_bad), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [17];
        obs_t        o;
        logic        e_err;
        logic [31:0] e_rdata, e_word, w;
        int          e_lat;
        logic        seen;
        logic [2:0]  legal [5];
        logic        r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_addr, r_wdata;
        int          sel;

        legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        vecs[0]  = '{1'b1, 3'b010, 32'h1EC,  32'h1234CDEF, 1'b0, 32'h0,        2, 12'd123};
        vecs[1]  = '{1'b0, 3'b010, 32'h1EC,  32'h0,        1'b0, 32'h1234CDEF, 3, 12'd123};
        vecs[2]  = '{1'b1, 3'b000, 32'h1ED,  32'hDEADBEAB, 1'b0, 32'h0,        4, 12'd123};
        vecs[3]  = '{1'b0, 3'b010, 32'h1EC,  32'h0,        1'b0, 32'h1234ABEF, 3, 12'd123};
        vecs[4]  = '{1'b0, 3'b000, 32'h1ED,  32'h0,        1'b0, 32'hFFFFFFAB, 3, 12'd123};
        vecs[5]  = '{1'b0, 3'b100, 32'h1ED,  32'h0,        1'b0, 32'h000000AB, 3, 12'd123};
        vecs[6]  = '{1'b1, 3'b001, 32'h1EE,  32'h55558001, 1'b0, 32'h0,        4, 12'd123};
        vecs[7]  = '{1'b0, 3'b010, 32'h1EC,  32'h0,        1'b0, 32'h8001ABEF, 3, 12'd123};
        vecs[8]  = '{1'b0, 3'b001, 32'h1EE,  32'h0,        1'b0, 32'hFFFF8001, 3, 12'd123};
        vecs[9]  = '{1'b0, 3'b101, 32'h1EE,  32'h0,        1'b0, 32'h00008001, 3, 12'd123};
        vecs[10] = '{1'b0, 3'b010, 32'h1EE,  32'h0,        1'b1, 32'h0,        1, 12'd0};
        vecs[11] = '{1'b0, 3'b001, 32'h1ED,  32'h0,        1'b1, 32'h0,        1, 12'd0};
        vecs[12] = '{1'b1, 3'b010, 32'h4000, 32'h11111111, 1'b1, 32'h0,        1, 12'd0};
        vecs[13] = '{1'b0, 3'b011, 32'h1EC,  32'h0,        1'b1, 32'h0,        1, 12'd0};
        vecs[14] = '{1'b1, 3'b100, 32'h1EC,  32'h000000FF, 1'b1, 32'h0,        1, 12'd0};
        vecs[15] = '{1'b1, 3'b010, 32'h3FFC, 32'hFFFFFFFF, 1'b0, 32'h0,        2, 12'hFFF};
        vecs[16] = '{1'b0, 3'b010, 32'h3FFC, 32'h0,        1'b0, 32'hFFFFFFFF, 3, 12'hFFF};

        for (int i = 0; i < 4096; i++) begin
            w      = $urandom;
            ram[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;

        #2 reset = 1'b1;
        #2;
        check("reset req_ready",   32'(bus.req_ready),  32'd1);
        check("reset resp_valid",  32'(bus.resp_valid), 32'd0);
        check("reset resp_err",    32'(bus.resp_err),   32'd0);
        check("reset resp_rdata",  bus.resp_rdata,      32'h0);
        check("reset ram_load",    32'(bus.ram_load),   32'd0);
        check("reset ram_store",   32'(bus.ram_store),  32'd0);
        check("reset ram_address", 32'(bus.ram_address), 32'h0);
        check("reset ram_data_in", bus.ram_data_in,     32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            model_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, e_err, e_rdata, e_lat, e_word);
            exec(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, e_word, o);
            check_op($sformatf("vec%0d", i), o, vecs[i].err, vecs[i].rdata, vecs[i].lat);
            if (vecs[i].lat > 1) check($sformatf("vec%0d ram_address", i), 32'(o.strobe_addr), 32'(vecs[i].idx));
        end

        // Reset while an SB sits in WAIT: nothing must be written or reported.
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h1EC;
        bus.req_wdata  = 32'h00000077;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("rstseq load strobe", 32'(bus.ram_load), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rstseq ram_load",    32'(bus.ram_load),    32'd0);
        check("rstseq ram_store",   32'(bus.ram_store),   32'd0);
        check("rstseq resp_valid",  32'(bus.resp_valid),  32'd0);
        check("rstseq req_ready",   32'(bus.req_ready),   32'd1);
        check("rstseq ram_address", 32'(bus.ram_address), 32'h0);
        check("rstseq ram_data_in", bus.ram_data_in,      32'h0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | bus.resp_valid | bus.ram_store | bus.ram_load;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | bus.resp_valid | bus.ram_store | bus.ram_load;
        end
        check("rstseq quiet", 32'(seen), 32'd0);
        check("rstseq ready after release", 32'(bus.req_ready), 32'd1);
        model_op(1'b0, 3'b010, 32'h1EC, 32'h0, e_err, e_rdata, e_lat, e_word);
        exec(1'b0, 3'b010, 32'h1EC, 32'h0, e_word, o);
        check_op("rstseq lw", o, 1'b0, 32'h8001ABEF, 3);

        for (int n = 0; n < 300; n++) begin
            r_we    = 1'($urandom);
            sel     = $urandom_range(0, 9);
            r_f3    = (sel < 8) ? legal[$urandom_range(0, 4)] : 3'($urandom);
            sel     = $urandom_range(0, 9);
            if (sel == 0)      r_addr = 32'($urandom_range(0, 63)) | (32'h1 << $urandom_range(14, 31));
            else if (sel == 1) r_addr = 32'h3FC0 + 32'($urandom_range(0, 63));
            else               r_addr = 32'($urandom_range(0, 63));
            r_wdata = $urandom;
            model_op(r_we, r_f3, r_addr, r_wdata, e_err, e_rdata, e_lat, e_word);
            exec(r_we, r_f3, r_addr, r_wdata, e_word, o);
            check_op($sformatf("rand%0d we=%0d f3=%0d addr=%08h", n, r_we, r_f3, r_addr),
                     o, e_err, e_rdata, e_lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: req_valid  in  1  CPU memory request present.
REQ-004 SHALL have: req_ready  out  1  unit idle and accepting a request.
REQ-005 SHALL have: req_we  in  1  1 = store, 0 = load.
REQ-006 SHALL have: req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have: req_addr  in  32  byte address.
REQ-008 SHALL have: req_wdata  in  32  store data; bytes used from the LSB end.
REQ-009 SHALL have: resp_valid  out  1  one-cycle completion pulse.
REQ-010 SHALL have: resp_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-011 SHALL have: resp_err  out  1  valid with resp_valid; misaligned, illegal or out-of-range access.
REQ-012 SHALL have: ram_address  out  12  word index, equal to req_addr[13:2].
REQ-013 SHALL have: ram_data_in  out  32  word to write.
REQ-014 SHALL have: ram_store  out  1  write strobe.
REQ-015 SHALL have: ram_load  out  1  read strobe.
REQ-016 SHALL have: ram_data_out  in  32  RAM read data, valid the cycle after ram_load.

Function
REQ-017 SHALL implement states IDLE, LOAD, WAIT, WRITE, DONE.
REQ-018 SHALL assert req_ready only in IDLE.
REQ-019 SHALL define the handshake as req_valid & req_ready at a rising edge, which captures all req_* fields; req_* SHALL be ignored in every other state.
REQ-020 SHALL flag an error on any of:
- funct3 not in {000, 001, 010, 100, 101};
- funct3 100/101 with req_we = 1;
- H/HU with addr[0] ≠ 0;
- W with addr[1:0] ≠ 0;
- req_addr[31:14] ≠ 0.
REQ-021 SHALL route the handshake to a next state as follows: error → DONE with resp_err = 1 and no RAM strobe; SW → WRITE; load, SB or SH → LOAD.
REQ-022 SHALL, in LOAD, drive ram_load = 1 and ram_address = captured word index, then go to WAIT.
REQ-023 SHALL, in WAIT, sample ram_data_out. Loads go to DONE with the result registered. SB/SH go to WRITE with the addressed byte or halfword of the read word replaced by req_wdata[7:0] or [15:0].
REQ-024 SHALL, in WRITE, drive ram_store = 1 with the merged word (SW: req_wdata unchanged), then go to DONE.
REQ-025 SHALL, in DONE, assert resp_valid for exactly one cycle, then return to IDLE.
REQ-026 SHALL build the load result by selecting a byte via addr[1:0] or a halfword via addr[1]. B/H SHALL sign-extend; BU/HU SHALL zero-extend.
REQ-027 SHALL hold latencies measured from the handshake edge T:
- error: resp_valid at T+1;
- SW: T+2;
- loads: T+3;
- SB/SH: T+4.
REQ-028 SHALL never assert ram_load and ram_store in the same cycle, and SHALL drive both low in IDLE and DONE.
REQ-029 SHALL drive ram_address and ram_data_in from registers only, so they are stable throughout every strobe cycle.
REQ-030 SHALL hold resp_rdata and resp_err at 0 whenever resp_valid = 0.

Reset
REQ-031 SHALL, on reset assertion, go immediately to IDLE and force req_ready = 1 and resp_valid = resp_err = ram_load = ram_store = 0. resp_rdata, ram_address and ram_data_in SHALL be forced to 0.
REQ-032 SHALL, on reset mid-operation, drop the pending request: no resp_valid, and no partial RMW write is issued.

Verification
REQ-033 SW 0x000001EC, data 0x1234CDEF, then LW 0x1EC → ram_address = 123; LW resp_rdata = 0x1234CDEF with resp_valid at T+3.
REQ-034 SB 0x1ED, data 0xAB → RMW visible as LOAD, WAIT, WRITE; then LW → 0x1234ABEF, LB 0x1ED → 0xFFFFFFAB, LBU → 0x000000AB.
REQ-035 SH 0x1EE, data 0x8001 → LW → 0x8001ABEF; LH 0x1EE → 0xFFFF8001; LHU → 0x00008001.
REQ-036 Each of LW 0x1EE, LH 0x1ED, SW 0x4000 and funct3 011 → resp_err = 1 at T+1, rdata 0, no ram strobe.
REQ-037 SW 0x3FFC, data 0xFFFFFFFF → ram_address = 0xFFF; LW 0x3FFC → 0xFFFFFFFF.
REQ-038 Reset pulsed during WAIT of an SB → ram strobes low immediately, no resp_valid, req_ready = 1 after release; the word still reads its prior value.
